adder_result_collector: RTL and testbench
=========================================

// Module: adder_result_collector
// PURPOSE
//  Downstream stage of sequential_adder: captures each valid sum and buffers it in an
//  in-order FIFO for a ready/valid consumer (scoreboard, bus bridge).
//  Recovers sum validity by delaying the adder's en_i by the adder latency.
//  Flags lost results.
// PARAMETERS
//  WIDTH    8  width of sum_i / out_data
//  DEPTH    8  FIFO entries; power of 2, >=2
//  LATENCY  1  cycles from en_i high to matching sum_i valid; >=1
// PORTS
//  clk        in   1                 clock; all state on posedge
//  reset      in   1                 asynchronous, active-low (0 = reset)
//  en_i       in   1                 adder enable, same signal that drives sequential_adder
//  sum_i      in   WIDTH             adder sum output
//  out_valid  out  1                 FIFO head valid
//  out_ready  in   1                 consumer accepts head
//  out_data   out  WIDTH             FIFO head value
//  count      out  $clog2(DEPTH)+1   entries held, 0..DEPTH
//  full       out  1                 count==DEPTH
//  empty      out  1                 count==0
//  overflow   out  1                 sticky: a valid sum was dropped
//  clr_ovf    in   1                 synchronous clear of overflow
// BEHAVIOUR
//  - Reset (async assert on reset==0, sync deassert by clk):
//    out_valid=0, out_data=0, count=0, full=0, empty=1, overflow=0.
//    Enable delay line is cleared; in-flight enables are discarded.
//  - Enable delay line: LATENCY-deep shift register of en_i; cap = last tap.
//  - sum_i is sampled on the clk edge where cap==1.
//  - push = cap && (!full || pop).
//  - pop  = out_valid && out_ready.
//  - Both pointers increment modulo DEPTH; count +1 / -1 / unchanged.
//  - Simultaneous push+pop:
//    - when full: the pop frees a slot; push accepted, count stays DEPTH, no overflow.
//    - when empty: impossible; out_valid=0, so no pop.
//  - Drop rule: cap && full && !pop drops the sum, sets overflow=1, leaves the FIFO unchanged.
//  - overflow clears on clr_ovf at the next edge. A new drop in the same cycle wins (stays 1).
//  - Write latency: sum pushed at edge N is visible on out_valid/out_data after edge N.
//    No same-cycle bypass when empty.
//  - Output is first-word-fall-through:
//    - out_data = mem[rd_ptr] when !empty, 0 when empty.
//    - out_valid = !empty.
//  - out_data is held stable while out_valid && !out_ready.
//  - Values are stored unmodified; no arithmetic on sum_i.
//  - Pointer wrap: rd/wr carry an extra MSB. full/empty come from pointer compare and must
//    agree with count.
//  - en_i pulses back-to-back every cycle are legal; a capture occurs every cycle.
// STRUCTURE
//  - adder_pkg: WIDTH/DEPTH/LATENCY defaults and cnt_t typedef (logic [$clog2(DEPTH):0]).
//    Shared with sequential_adder and the bench.
//  - Sub-module result_fifo: generic sync FIFO (push/pop/data/count/full/empty).
//  - Top holds the enable delay line and overflow logic.
// TESTING
//  1. Reset mid-stream: en_i pulses; reset=0 one cycle after en_i
//     -> count=0, out_valid=0, no capture of that sum after release.
//  2. Single capture: in1=3, in2=4, en_i 1 cycle, out_ready=0
//     -> LATENCY+1 edges later out_valid=1, out_data=7, count=1.
//  3. Fill to full: 8 sums 1..8 with out_ready=0
//     -> full=1, count=8.
//     9th sum (9) -> dropped, overflow=1, head still 1.
//  4. Full plus simultaneous pop: full FIFO, out_ready=1 with new sum 20
//     -> count stays 8, overflow stays 0, 20 drains last.
//  5. Order and wrap: 20 sums with random out_ready backpressure
//     -> drained in input order, no loss; pointers wrap twice.
//  6. Overflow clear: assert clr_ovf with no drop -> overflow=0.
//     Assert clr_ovf in the same cycle as a drop -> overflow=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults for the sequential adder, its result collector and the bench.
package adder_pkg;
  localparam int ADDER_WIDTH   = 8;
  localparam int ADDER_DEPTH   = 8;
  localparam int ADDER_LATENCY = 1;

  typedef logic [$clog2(ADDER_DEPTH):0] cnt_t;
endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO, first-word-fall-through, pointers with a wrap bit.
module result_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       wdata,
  input  logic               pop,
  output logic [W-1:0]       rdata,
  output logic [$clog2(D):0] count,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(D);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Same index with opposite wrap bits means every slot is occupied.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/adder_result_collector.sv
// Captures sequential_adder sums (validity rebuilt from a delayed en_i) into an
// in-order FIFO for a ready/valid consumer; flags sums lost to a full FIFO.
module adder_result_collector import adder_pkg::*; #(
  parameter int WIDTH   = ADDER_WIDTH,
  parameter int DEPTH   = ADDER_DEPTH,
  parameter int LATENCY = ADDER_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       sum_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  logic [LATENCY:1] vld_pipe;
  logic             cap, push, pop, drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= en_i;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign cap  = vld_pipe[LATENCY];
  assign pop  = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  result_fifo #(.W(WIDTH), .D(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (sum_i),
    .pop   (pop),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector: behavioral adder in front, scoreboard on the drain side.
module tb_adder_result_collector;
  import adder_pkg::*;

  localparam int W = ADDER_WIDTH;
  localparam int D = ADDER_DEPTH;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en_i = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] sum_i = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] out_data;
  cnt_t         count;
  logic         full, empty, overflow;
  logic         clr_ovf = 1'b0;

  int tests = 0;
  int fails = 0;
  int q[$];

  always #5 clk = ~clk;

  // Single-cycle adder: sum registered on the edge where en_i is high.
  always @(posedge clk) if (en_i) sum_i <= W'(a + b);

  adder_result_collector dut (
    .clk       (clk),
    .reset     (reset),
    .en_i      (en_i),
    .sum_i     (sum_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input int v, input int d,
                           input int f, input int e, input int o);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".valid"}, int'(out_valid), v);
    chk({tag, ".data"}, int'(out_data), d);
    chk({tag, ".full"}, int'(full), f);
    chk({tag, ".empty"}, int'(empty), e);
    chk({tag, ".ovf"}, int'(overflow), o);
  endtask

  // Consumer side: a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      chk("flags_vs_count", {int'(full), int'(empty)},
          {int'(count == D), int'(count == 0)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_pop", int'(out_data), -1);
        else chk("drain_order", int'(out_data), q.pop_front());
      end
    end
  end

  typedef struct {
    logic en; int av; logic ready; logic clr; logic keep;
    int c; int v; int d; int f; int e; int o;
  } vec_t;

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1'b1;
    while (!empty && n < 100) begin tick(); n++; end
    out_ready = 1'b0;
    chk({tag, ".drained"}, int'(empty), 1);
    chk({tag, ".queue_left"}, q.size(), 0);
  endtask

  initial begin
    vec_t vec[15];
    // Fill 1..8, drop 9, then overflow clear with and without a concurrent drop.
    vec[0]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    vec[1]  = '{1, 2, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    vec[2]  = '{1, 3, 0, 0, 1, 2, 1, 1, 0, 0, 0};
    vec[3]  = '{1, 4, 0, 0, 1, 3, 1, 1, 0, 0, 0};
    vec[4]  = '{1, 5, 0, 0, 1, 4, 1, 1, 0, 0, 0};
    vec[5]  = '{1, 6, 0, 0, 1, 5, 1, 1, 0, 0, 0};
    vec[6]  = '{1, 7, 0, 0, 1, 6, 1, 1, 0, 0, 0};
    vec[7]  = '{1, 8, 0, 0, 1, 7, 1, 1, 0, 0, 0};
    vec[8]  = '{1, 9, 0, 0, 0, 8, 1, 1, 1, 0, 0};
    vec[9]  = '{0, 0, 0, 0, 0, 8, 1, 1, 1, 0, 1};
    vec[10] = '{0, 0, 0, 1, 0, 8, 1, 1, 1, 0, 0};
    vec[11] = '{1, 50, 0, 0, 0, 8, 1, 1, 1, 0, 0};
    vec[12] = '{0, 0, 0, 1, 0, 8, 1, 1, 1, 0, 1};
    vec[13] = '{0, 0, 0, 0, 0, 8, 1, 1, 1, 0, 1};
    vec[14] = '{0, 0, 0, 1, 0, 8, 1, 1, 1, 0, 0};

    // Reset state and reset discarding an in-flight enable.
    repeat (2) tick();
    chk_state("reset", 0, 0, 0, 0, 1, 0);
    reset = 1'b1;
    tick();
    en_i = 1'b1; a = 8'd5; b = 8'd0;
    tick();
    en_i = 1'b0;
    reset = 1'b0;
    #2 chk("mid_reset.count", int'(count), 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk_state("after_reset", 0, 0, 0, 0, 1, 0);

    // Single capture 3+4: visible LATENCY+1 edges after the enable.
    en_i = 1'b1; a = 8'd3; b = 8'd4;
    q.push_back(7);
    tick();
    en_i = 1'b0;
    chk("single.early_valid", int'(out_valid), 0);
    tick();
    chk_state("single", 1, 1, 7, 0, 0, 0);
    tick();
    chk("single.hold", int'(out_data), 7);
    drain("single");

    for (int i = 0; i < 15; i++) begin
      en_i = vec[i].en; a = W'(vec[i].av); b = '0;
      out_ready = vec[i].ready; clr_ovf = vec[i].clr;
      if (vec[i].keep) q.push_back(vec[i].av);
      tick();
      chk_state($sformatf("vec%0d", i), vec[i].c, vec[i].v, vec[i].d,
                vec[i].f, vec[i].e, vec[i].o);
    end
    en_i = 1'b0; clr_ovf = 1'b0;

    // Full FIFO, new sum arrives in the same cycle as a pop.
    en_i = 1'b1; a = 8'd20; b = 8'd0;
    q.push_back(20);
    tick();
    en_i = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_state("full_pop", 8, 1, 2, 1, 0, 0);
    drain("full_pop");

    // Random backpressure, throttled so nothing can be dropped.
    begin
      int issued = 0, cyc = 0;
      while (issued < 20 && cyc < 500) begin
        en_i = (int'(count) <= D - 2) && ($urandom_range(0, 3) != 0);
        a = W'(100 + issued); b = W'(issued);
        if (en_i) begin q.push_back(100 + 2 * issued); issued++; end
        out_ready = ($urandom_range(0, 1) == 1);
        tick();
        cyc++;
      end
      en_i = 1'b0;
      chk("random.issued", issued, 20);
      tick();
      drain("random");
      chk_state("random_end", 0, 0, 0, 0, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
